// File: rtl/prog_loader.sv
// prog_loader: receives a framed program image over a byte stream, writes it
// word by word into instruction memory and releases the CPU once the checksum verifies.
module prog_loader #(
  parameter int unsigned TIMEOUT = 65535,
  parameter logic [7:0]  SYNC    = 8'hA5
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic [7:0]  rxData,
  input  logic        rxValid,
  output logic        imemWrEn,
  output logic [11:0] imemAddress,
  output logic [31:0] imemData,
  output logic        cpuRstN,
  output logic [7:0]  loadStatus,
  output logic [1:0]  errCode
);

  // The counter only ever needs to hold TIMEOUT-1 idle cycles.
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t        state_r;
  state_t        state_nx_s;
  logic [15:0]   len_r;
  logic [23:0]   shift_r;
  logic [1:0]    byte_idx_r;
  logic [11:0]   word_addr_r;
  logic [7:0]    csum_r;
  logic [TW-1:0] tmo_cnt_r;

  logic [15:0]   len_s;
  logic          active_s;
  logic          timeout_s;
  logic          last_word_s;
  logic          wr_nx_s;
  logic [31:0]   data_nx_s;
  logic [7:0]    status_nx_s;
  logic [1:0]    err_nx_s;

  assign len_s       = {rxData, len_r[7:0]};
  assign active_s    = (state_r == S_LEN_LO) || (state_r == S_LEN_HI) ||
                       (state_r == S_DATA)   || (state_r == S_CHECK);
  assign timeout_s   = active_s && !rxValid && (tmo_cnt_r == TW'(TIMEOUT - 1));
  assign last_word_s = ({4'd0, word_addr_r} == (len_r - 16'd1));

  // State register
  always_ff @(posedge clk) begin
    if (nRst) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state logic; timeout wins because it can only fire without a byte
  always_comb begin
    state_nx_s = state_r;
    if (timeout_s) begin
      state_nx_s = S_ERROR;
    end else if (rxValid) begin
      case (state_r)
        S_IDLE: begin
          if (rxData == SYNC) state_nx_s = S_LEN_LO;
          else                state_nx_s = S_IDLE;
        end
        S_LEN_LO: state_nx_s = S_LEN_HI;
        S_LEN_HI: begin
          if (len_s > 16'd4096)     state_nx_s = S_ERROR;
          else if (len_s == 16'd0)  state_nx_s = S_CHECK;
          else                      state_nx_s = S_DATA;
        end
        S_DATA: begin
          if ((byte_idx_r == 2'd3) && last_word_s) state_nx_s = S_CHECK;
          else                                     state_nx_s = S_DATA;
        end
        S_CHECK: begin
          if (rxData == csum_r) state_nx_s = S_DONE;
          else                  state_nx_s = S_ERROR;
        end
        default: state_nx_s = state_r;
      endcase
    end else begin
      state_nx_s = state_r;
    end
  end

  // Output decode: next values of the registered outputs
  always_comb begin
    wr_nx_s   = (state_r == S_DATA) && rxValid && (byte_idx_r == 2'd3);
    data_nx_s = {rxData, shift_r};
    case (state_nx_s)
      S_IDLE:   status_nx_s = 8'h00;
      S_LEN_LO: status_nx_s = 8'h01;
      S_LEN_HI: status_nx_s = 8'h02;
      S_DATA:   status_nx_s = 8'h03;
      S_CHECK:  status_nx_s = 8'h04;
      S_DONE:   status_nx_s = 8'h05;
      S_ERROR:  status_nx_s = 8'h80;
      default:  status_nx_s = 8'h80;
    endcase
    if ((state_r != S_ERROR) && (state_nx_s == S_ERROR)) begin
      if (timeout_s)                 err_nx_s = 2'b11;
      else if (state_r == S_LEN_HI)  err_nx_s = 2'b10;
      else                           err_nx_s = 2'b01;
    end else begin
      err_nx_s = errCode;
    end
  end

  // Frame datapath: length, word assembly, checksum, idle-cycle counter
  always_ff @(posedge clk) begin
    if (nRst) begin
      len_r       <= 16'd0;
      shift_r     <= 24'd0;
      byte_idx_r  <= 2'd0;
      word_addr_r <= 12'd0;
      csum_r      <= 8'd0;
      tmo_cnt_r   <= '0;
    end else begin
      if (rxValid || (state_nx_s != state_r)) tmo_cnt_r <= '0;
      else if (active_s)                      tmo_cnt_r <= tmo_cnt_r + 1'b1;
      else                                    tmo_cnt_r <= tmo_cnt_r;
      if (rxValid) begin
        case (state_r)
          S_IDLE: begin
            if (rxData == SYNC) begin
              len_r       <= 16'd0;
              byte_idx_r  <= 2'd0;
              word_addr_r <= 12'd0;
              csum_r      <= 8'd0;
            end
          end
          S_LEN_LO: len_r[7:0]  <= rxData;
          S_LEN_HI: len_r[15:8] <= rxData;
          S_DATA: begin
            // Little-endian: earliest byte ends up in the lowest lane
            shift_r    <= {rxData, shift_r[23:8]};
            byte_idx_r <= byte_idx_r + 2'd1;
            csum_r     <= csum_r ^ rxData;
            if (byte_idx_r == 2'd3) word_addr_r <= word_addr_r + 12'd1;
          end
          default: ;
        endcase
      end
    end
  end

  // Registered outputs; CPU release lags DONE entry by one cycle
  always_ff @(posedge clk) begin
    if (nRst) begin
      imemWrEn    <= 1'b0;
      imemAddress <= 12'd0;
      imemData    <= 32'd0;
      cpuRstN     <= 1'b0;
      loadStatus  <= 8'h00;
      errCode     <= 2'b00;
    end else begin
      imemWrEn <= wr_nx_s;
      if (wr_nx_s) begin
        imemAddress <= word_addr_r;
        imemData    <= data_nx_s;
      end
      cpuRstN    <= (state_r == S_DONE);
      loadStatus <= status_nx_s;
      errCode    <= err_nx_s;
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: byte-count reference model compared every
// cycle, directed frames with literal expectations, then randomized frames.
module tb_prog_loader;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic [7:0]  rxData = 8'h00;
  logic        rxValid = 1'b0;
  logic        imemWrEn;
  logic [11:0] imemAddress;
  logic [31:0] imemData;
  logic        cpuRstN;
  logic [7:0]  loadStatus;
  logic [1:0]  errCode;

  prog_loader #(.TIMEOUT(TMO), .SYNC(8'hA5)) dut (
    .clk(clk), .nRst(nRst), .rxData(rxData), .rxValid(rxValid),
    .imemWrEn(imemWrEn), .imemAddress(imemAddress), .imemData(imemData),
    .cpuRstN(cpuRstN), .loadStatus(loadStatus), .errCode(errCode)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: tracks the frame as a byte count after SYNC
  logic [7:0]  m_code = 8'h00;
  logic [1:0]  m_err = 2'b00;
  logic        m_wr = 1'b0;
  logic        m_rst = 1'b1;
  logic [11:0] m_addr = 12'd0;
  logic [31:0] m_data = 32'd0;
  logic        m_cpu = 1'b0;
  logic [7:0]  m_xor = 8'h00;
  logic [7:0]  m_w [4];
  int          m_len = 0;
  int          m_nb = 0;
  int          m_idle = 0;

  always @(posedge clk) begin
    if (nRst) begin
      m_code = 8'h00; m_err = 2'b00; m_wr = 1'b0; m_cpu = 1'b0;
      m_addr = 12'd0; m_data = 32'd0; m_idle = 0; m_rst = 1'b1;
    end else begin
      m_rst = 1'b0;
      m_cpu = (m_code == 8'h05);
      m_wr  = 1'b0;
      if (rxValid) begin
        m_idle = 0;
        case (m_code)
          8'h00: if (rxData == 8'hA5) begin m_code = 8'h01; m_xor = 8'h00; m_nb = 0; end
          8'h01: begin m_len = int'(rxData); m_code = 8'h02; end
          8'h02: begin
            m_len = m_len + 256 * int'(rxData);
            if (m_len > 4096) begin m_code = 8'h80; m_err = 2'b10; end
            else if (m_len == 0) m_code = 8'h04;
            else m_code = 8'h03;
          end
          8'h03: begin
            m_w[m_nb % 4] = rxData;
            m_xor = m_xor ^ rxData;
            m_nb++;
            if (m_nb % 4 == 0) begin
              m_wr = 1'b1;
              m_addr = 12'(m_nb / 4 - 1);
              m_data = {m_w[3], m_w[2], m_w[1], m_w[0]};
            end
            if (m_nb == 4 * m_len) m_code = 8'h04;
          end
          8'h04: begin
            if (rxData == m_xor) m_code = 8'h05;
            else begin m_code = 8'h80; m_err = 2'b01; end
          end
          default: ;
        endcase
      end else if (m_code >= 8'h01 && m_code <= 8'h04) begin
        m_idle++;
        if (m_idle == TMO) begin m_code = 8'h80; m_err = 2'b11; end
      end
    end
  end

  logic [43:0] wq[$];

  // Per-cycle compare against the model, and a log of DUT writes
  always @(negedge clk) begin
    check("wr_en", imemWrEn, m_wr);
    check("status", loadStatus, m_code);
    check("err", errCode, m_err);
    check("cpu_rst_n", cpuRstN, m_cpu);
    if (m_wr || m_rst) begin
      check("addr", imemAddress, m_addr);
      check("data", imemData, m_data);
    end
    if (imemWrEn) wq.push_back({imemAddress, imemData});
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rxData = b; rxValid = 1'b1;
    @(posedge clk); #1;
    rxValid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    if (gap > 0) idle(gap);
    send(b);
  endtask

  // Reset with a byte present, to show reset wins over rxValid
  task automatic do_reset();
    nRst = 1'b1; rxValid = 1'b1; rxData = 8'hA5;
    @(posedge clk); #1;
    nRst = 1'b0; rxValid = 1'b0;
  endtask

  logic [7:0] fr[$];

  task automatic send_fr();
    foreach (fr[i]) send(fr[i]);
  endtask

  task automatic rand_frame();
    int len;
    int r;
    logic [7:0] x;
    logic [7:0] b;
    repeat ($urandom_range(0, 2)) begin
      x = 8'($urandom_range(0, 255));
      if (x == 8'hA5) x = 8'h00;
      send_gap(x, $urandom_range(0, 2));
    end
    len = ($urandom_range(0, 14) == 0) ? 4097 + $urandom_range(0, 3) : $urandom_range(0, 5);
    fr = {8'hA5, 8'(len), 8'(len >> 8)};
    x = 8'h00;
    if (len <= 4096) begin
      for (int i = 0; i < 4 * len; i++) begin
        b = ($urandom_range(0, 9) == 0) ? 8'hA5 : 8'($urandom);
        fr.push_back(b);
        x = x ^ b;
      end
      if ($urandom_range(0, 4) == 0) fr.push_back(x ^ 8'(1 << $urandom_range(0, 7)));
      else fr.push_back(x);
    end
    foreach (fr[i]) begin
      r = $urandom_range(0, 39);
      send_gap(fr[i], (r == 0) ? TMO : (r == 1) ? TMO - 1 : (r < 8) ? $urandom_range(1, 3) : 0);
    end
    idle(2);
    send(8'($urandom));
    idle(2);
    do_reset();
  endtask

  logic [7:0] bx;

  initial begin
    idle(2);
    nRst = 1'b0;
    check("rst_status", loadStatus, 32'h00);
    check("rst_cpu", cpuRstN, 32'h0);
    check("rst_wr", imemWrEn, 32'h0);
    check("rst_err", errCode, 32'h0);
    check("rst_addr", imemAddress, 32'h0);

    // Single word frame
    wq.delete();
    fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_fr(); idle(2);
    check("f1_nwr", wq.size(), 32'd1);
    if (wq.size() > 0) begin
      check("f1_addr", wq[0][43:32], 32'h000);
      check("f1_data", wq[0][31:0], 32'h12345678);
    end
    check("f1_status", loadStatus, 32'h05);
    check("f1_err", errCode, 32'h0);
    check("f1_cpu", cpuRstN, 32'h1);
    do_reset();

    // Two words
    wq.delete();
    fr = {8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h08};
    send_fr(); idle(2);
    check("f2_nwr", wq.size(), 32'd2);
    if (wq.size() > 1) begin
      check("f2_a0", wq[0][43:32], 32'h000);
      check("f2_d0", wq[0][31:0], 32'h04030201);
      check("f2_a1", wq[1][43:32], 32'h001);
      check("f2_d1", wq[1][31:0], 32'h08070605);
    end
    check("f2_status", loadStatus, 32'h05);
    do_reset();

    // SYNC bytes inside the payload are data
    wq.delete();
    fr = {8'hA5, 8'h01, 8'h00, 8'hA5, 8'hA5, 8'hA5, 8'hA5, 8'h00};
    send_fr(); idle(2);
    check("f3_nwr", wq.size(), 32'd1);
    if (wq.size() > 0) check("f3_data", wq[0][31:0], 32'hA5A5A5A5);
    check("f3_status", loadStatus, 32'h05);
    do_reset();

    // Bad checksum
    wq.delete();
    fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h09};
    send_fr(); idle(3);
    check("f4_status", loadStatus, 32'h80);
    check("f4_err", errCode, 32'h1);
    check("f4_cpu", cpuRstN, 32'h0);
    do_reset();

    // Oversize length, then empty frame
    wq.delete();
    fr = {8'hA5, 8'h01, 8'h10};
    send_fr(); idle(2);
    check("f5_status", loadStatus, 32'h80);
    check("f5_err", errCode, 32'h2);
    check("f5_nwr", wq.size(), 32'd0);
    do_reset();
    fr = {8'hA5, 8'h00, 8'h00, 8'h00};
    send_fr(); idle(2);
    check("f6_status", loadStatus, 32'h05);
    check("f6_nwr", wq.size(), 32'd0);
    do_reset();

    // Timeout boundary: TMO idle cycles aborts, TMO-1 does not
    fr = {8'hA5, 8'h01};
    send_fr(); idle(TMO);
    check("t1_status", loadStatus, 32'h80);
    check("t1_err", errCode, 32'h3);
    do_reset();
    send_fr(); idle(TMO - 1);
    check("t2_status", loadStatus, 32'h02);
    send(8'h00);
    check("t2_status_b", loadStatus, 32'h03);
    check("t2_err", errCode, 32'h0);
    do_reset();

    // Reset mid-frame, then a clean frame
    wq.delete();
    fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34};
    send_fr(); do_reset(); idle(1);
    check("r1_nwr", wq.size(), 32'd0);
    fr = {8'hA5, 8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'h08};
    send_fr(); idle(2);
    check("r1_nwr_after", wq.size(), 32'd1);
    if (wq.size() > 0) check("r1_data", wq[0][31:0], 32'h12345678);
    check("r1_status", loadStatus, 32'h05);
    do_reset();

    // Maximum length frame, back to back
    wq.delete();
    fr = {8'hA5, 8'h00, 8'h10};
    bx = 8'h00;
    for (int i = 0; i < 16384; i++) begin
      fr.push_back(8'($urandom));
      bx = bx ^ fr[fr.size() - 1];
    end
    fr.push_back(bx);
    send_fr(); idle(2);
    check("max_nwr", wq.size(), 32'd4096);
    if (wq.size() == 4096) check("max_last_addr", wq[4095][43:32], 32'hFFF);
    check("max_status", loadStatus, 32'h05);
    do_reset();

    for (int k = 0; k < 80; k++) rand_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter TIMEOUT, default 65535: idle cycles tolerated between bytes inside a frame before abort.
REQ-002 Parameter SYNC, default 8'hA5: frame start byte.
REQ-003 Reset nRst, synchronous, active-high; clock clk.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 nRst  in  1  synchronous reset, asserted when high.
REQ-006 rxData  in  8  received byte from serial receiver.
REQ-007 rxValid  in  1  one-cycle strobe; rxData valid this cycle.
REQ-008 imemWrEn  out  1  instruction-memory write strobe.
REQ-009 imemAddress  out  12  instruction-memory word address.
REQ-010 imemData  out  32  instruction word to write.
REQ-011 cpuRstN  out  1  drives CPU reset; low holds CPU in reset.
REQ-012 loadStatus  out  8  state code: 00 IDLE, 01 LEN_LO, 02 LEN_HI, 03 DATA, 04 CHECK, 05 DONE, 80 ERROR.
REQ-013 errCode  out  2  00 none, 01 checksum, 10 length>4096, 11 timeout.

Function
REQ-014 Frame SHALL be: SYNC, len[7:0], len[15:8], len*4 payload bytes (each word little-endian), one checksum byte equal to XOR of all payload bytes.
REQ-015 IDLE: SHALL discard bytes other than SYNC; SYNC -> LEN_LO, clear checksum, byte index, and word address.
REQ-016 LEN_LO -> LEN_HI on next byte; LEN_HI -> DATA if 1<=len<=4096, CHECK if len==0, ERROR (errCode 10) if len>4096.
REQ-017 DATA: bytes assembled LSB first into a 32-bit shift register; 2-bit byte index wraps 3 -> 0.
REQ-018 On the fourth byte of a word, imemWrEn SHALL pulse high exactly one cycle, the cycle after that byte's rxValid, with imemAddress = word index (0-based) and imemData = assembled word.
REQ-019 Word address SHALL increment after each write; after word len-1 state -> CHECK; address 4095 -> no wrap is used because len<=4096.
REQ-020 Every payload byte SHALL be XORed into a running 8-bit checksum on acceptance.
REQ-021 CHECK: next byte compared with checksum; equal -> DONE, else ERROR (errCode 01).
REQ-022 DONE SHALL be terminal until reset; further bytes ignored; cpuRstN high.
REQ-023 ERROR SHALL be terminal until reset; imemWrEn low; cpuRstN low; loadStatus 8'h80.
REQ-024 Timeout counter SHALL clear on every rxValid and on state entry; in LEN_LO, LEN_HI, DATA, CHECK reaching TIMEOUT cycles without rxValid -> ERROR (errCode 11); counter inactive in IDLE, DONE, ERROR.
REQ-025 At most one byte accepted per cycle; rxValid on consecutive cycles SHALL all be accepted (no backpressure).
REQ-026 cpuRstN SHALL be low in every state except DONE, rising the cycle after DONE entry, so CPU starts fetching at address 0 only after the last word is written.
REQ-027 imemWrEn SHALL never be high outside DATA-generated pulses.
REQ-028 A byte equal to SYNC inside a frame SHALL be treated as data, never as resynchronisation.

Reset
REQ-029 While nRst high at a clock edge: state IDLE, imemWrEn 0, imemAddress 0, imemData 0, cpuRstN 0, loadStatus 00, errCode 00, checksum, byte index, length, timeout counter 0.
REQ-030 Reset mid-frame SHALL abandon the frame with no further writes; already-written memory words are not recovered.
REQ-031 Reset takes priority over rxValid in the same cycle.

Verification
REQ-032 A5 01 00 78 56 34 12 08 -> one write addr 0 data 32'h12345678; DONE; cpuRstN rises; errCode 00.
REQ-033 A5 02 00 + 8 bytes 01..08 + checksum 08 -> writes addr0 32'h04030201, addr1 32'h08070605; DONE.
REQ-034 Same as REQ-032 with checksum 09 -> ERROR, errCode 01, cpuRstN stays 0, loadStatus 80.
REQ-035 A5 01 10 -> ERROR, errCode 10, no writes; A5 00 00 00 -> DONE, no writes.
REQ-036 TIMEOUT=16: A5 01 then 16 idle cycles -> ERROR, errCode 11; repeat with 15 idle cycles then byte -> no error.
REQ-037 Assert nRst after third payload byte, then send REQ-032 frame -> no write before reset, correct single write after, DONE.
